// File: rtl/cfg_uart_pkg.sv
// Shared definitions for the 3-byte configuration UART link.
// Used by both the host-side initiator and the device-side receiver.
package cfg_uart_pkg;

    localparam int          CMD_BYTES       = 3;
    localparam int          RSP_BYTES       = 2;
    localparam int          TO_CNT_W        = 22;
    localparam logic [21:0] TIMEOUT_CYC_DEF = 22'd2_000_000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_MSB  = 3'd1,
        TX_B2   = 3'd2,
        TX_LSB  = 3'd3,
        WAIT_R1 = 3'd4,
        WAIT_R2 = 3'd5,
        RSP_RDY = 3'd6
    } cfg_state_e;

    // Byte idx of a command word, counted from the MSB (idx 0 goes out first).
    function automatic logic [7:0] cmd_byte(input logic [8*CMD_BYTES-1:0] c,
                                            input logic [1:0]             idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = c[23:16];
            2'd1:    b = c[15:8];
            default: b = c[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/UART.sv
// 8N1 UART transceiver. tx_done stays high from end of stop bit until the next trmt;
// rdy stays high until clr_rdy. rx_data is valid while rdy is high.
module UART #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rdy,
    input  logic       clr_rdy,
    output logic       TX,
    input  logic       RX
);

    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
    localparam logic [15:0] BAUD_HALF   = 16'(BAUD_DIV / 2 - 1);

    logic [8:0]  tx_shft_q, tx_shft_d;
    logic [15:0] tx_baud_q, tx_baud_d;
    logic [3:0]  tx_bits_q, tx_bits_d;
    logic        tx_busy_q, tx_busy_d;
    logic        tx_done_q, tx_done_d;

    logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic [7:0]  rx_shft_q, rx_shft_d;
    logic [15:0] rx_baud_q, rx_baud_d;
    logic [3:0]  rx_bits_q, rx_bits_d;
    logic        rx_busy_q, rx_busy_d;
    logic        rdy_q, rdy_d;

    always_comb begin
        tx_shft_d = tx_shft_q;
        tx_baud_d = tx_baud_q;
        tx_bits_d = tx_bits_q;
        tx_busy_d = tx_busy_q;
        tx_done_d = tx_done_q;
        if (trmt) begin
            tx_shft_d = {tx_data, 1'b0};
            tx_baud_d = BAUD_RELOAD;
            tx_bits_d = 4'd0;
            tx_busy_d = 1'b1;
            tx_done_d = 1'b0;
        end else if (tx_busy_q) begin
            if (tx_baud_q == 16'd0) begin
                // ones shift in behind the data, so the last period is the stop bit
                tx_shft_d = {1'b1, tx_shft_q[8:1]};
                tx_baud_d = BAUD_RELOAD;
                tx_bits_d = tx_bits_q + 4'd1;
                if (tx_bits_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    tx_done_d = 1'b1;
                end
            end else begin
                tx_baud_d = tx_baud_q - 16'd1;
            end
        end
    end

    always_comb begin
        rx_shft_d = rx_shft_q;
        rx_baud_d = rx_baud_q;
        rx_bits_d = rx_bits_q;
        rx_busy_d = rx_busy_q;
        rdy_d     = clr_rdy ? 1'b0 : rdy_q;
        if (!rx_busy_q) begin
            if (rx_prev_q && !rx_sync2_q) begin
                rx_busy_d = 1'b1;
                rx_baud_d = BAUD_HALF;
                rx_bits_d = 4'd0;
            end
        end else if (rx_baud_q == 16'd0) begin
            rx_baud_d = BAUD_RELOAD;
            rx_bits_d = rx_bits_q + 4'd1;
            if (rx_bits_q == 4'd0) begin
                // start bit no longer low at mid-bit: glitch, drop it
                if (rx_sync2_q) rx_busy_d = 1'b0;
            end else begin
                rx_shft_d = {rx_sync2_q, rx_shft_q[7:1]};
                if (rx_bits_q == 4'd8) begin
                    rx_busy_d = 1'b0;
                    rdy_d     = 1'b1;
                end
            end
        end else begin
            rx_baud_d = rx_baud_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft_q  <= 9'h1FF;
            tx_baud_q  <= 16'd0;
            tx_bits_q  <= 4'd0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_shft_q  <= 8'h00;
            rx_baud_q  <= 16'd0;
            rx_bits_q  <= 4'd0;
            rx_busy_q  <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            tx_shft_q  <= tx_shft_d;
            tx_baud_q  <= tx_baud_d;
            tx_bits_q  <= tx_bits_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
            rx_sync1_q <= RX;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rx_shft_q  <= rx_shft_d;
            rx_baud_q  <= rx_baud_d;
            rx_bits_q  <= rx_bits_d;
            rx_busy_q  <= rx_busy_d;
            rdy_q      <= rdy_d;
        end
    end

    assign TX      = tx_shft_q[0];
    assign tx_done = tx_done_q;
    assign rx_data = rx_shft_q;
    assign rdy     = rdy_q;

endmodule

// File: rtl/cfg_host_uart.sv
// Host-side initiator: sends a 24-bit command MSB first, collects a 16-bit response.
//   state   | meaning
//   IDLE    | waiting for snd_cmd
//   TX_MSB  | cmd[23:16] on the wire
//   TX_B2   | cmd[15:8] on the wire
//   TX_LSB  | cmd[7:0] on the wire
//   WAIT_R1 | waiting for response high byte, timeout running
//   WAIT_R2 | waiting for response low byte, timeout running
//   RSP_RDY | resp valid until acknowledged or a new command
module cfg_host_uart
    import cfg_uart_pkg::*;
#(
    parameter logic [21:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int          BAUD_DIV    = 434
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     snd_cmd,
    input  logic [8*CMD_BYTES-1:0]   cmd,
    input  logic                     clr_resp_rdy,
    input  logic                     RX,
    output logic                     TX,
    output logic                     busy,
    output logic                     resp_rdy,
    output logic [8*RSP_BYTES-1:0]   resp,
    output logic                     timeout
);

    localparam logic [TO_CNT_W-1:0] TO_LAST = TIMEOUT_CYC - 22'd1;

    cfg_state_e             state_q, state_d;
    logic [8*CMD_BYTES-1:0] cmd_q, cmd_d;
    logic [7:0]             resp_hi_q, resp_hi_d;
    logic [8*RSP_BYTES-1:0] resp_q, resp_d;
    logic                   resp_rdy_q, resp_rdy_d;
    logic                   busy_q, busy_d;
    logic                   timeout_q, timeout_d;
    logic [TO_CNT_W-1:0]    to_cnt_q, to_cnt_d;

    logic [7:0] tx_data;
    logic       trmt;
    logic       tx_done;
    logic [7:0] rx_data;
    logic       rdy;
    logic       clr_rdy;

    UART #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk    (clk),
        .rst_n  (rst_n),
        .tx_data(tx_data),
        .trmt   (trmt),
        .tx_done(tx_done),
        .rx_data(rx_data),
        .rdy    (rdy),
        .clr_rdy(clr_rdy),
        .TX     (TX),
        .RX     (RX)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        resp_hi_d  = resp_hi_q;
        resp_d     = resp_q;
        resp_rdy_d = resp_rdy_q;
        busy_d     = busy_q;
        timeout_d  = timeout_q;
        to_cnt_d   = to_cnt_q;
        trmt       = 1'b0;
        clr_rdy    = 1'b0;
        tx_data    = cmd_byte(cmd_q, 2'd0);

        case (state_q)
            IDLE, RSP_RDY: begin
                clr_rdy = rdy;
                if (snd_cmd) begin
                    // first byte comes straight from cmd; cmd_q is not loaded yet
                    cmd_d      = cmd;
                    tx_data    = cmd_byte(cmd, 2'd0);
                    trmt       = 1'b1;
                    timeout_d  = 1'b0;
                    resp_rdy_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = TX_MSB;
                end else if ((state_q == RSP_RDY) && clr_resp_rdy) begin
                    resp_rdy_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            TX_MSB: begin
                clr_rdy = rdy;
                tx_data = cmd_byte(cmd_q, 2'd1);
                if (tx_done) begin
                    trmt    = 1'b1;
                    state_d = TX_B2;
                end
            end
            TX_B2: begin
                clr_rdy = rdy;
                tx_data = cmd_byte(cmd_q, 2'd2);
                if (tx_done) begin
                    trmt    = 1'b1;
                    state_d = TX_LSB;
                end
            end
            TX_LSB: begin
                clr_rdy = rdy;
                if (tx_done) begin
                    to_cnt_d = '0;
                    state_d  = WAIT_R1;
                end
            end
            WAIT_R1, WAIT_R2: begin
                to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 22'd1;
                // a byte arriving on the last allowed cycle still counts
                if (rdy) begin
                    clr_rdy = 1'b1;
                    if (state_q == WAIT_R1) begin
                        resp_hi_d = rx_data;
                        state_d   = WAIT_R2;
                    end else begin
                        resp_d     = {resp_hi_q, rx_data};
                        resp_rdy_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = RSP_RDY;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    clr_rdy   = 1'b1;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            resp_hi_q  <= 8'h00;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            resp_hi_q  <= resp_hi_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign resp_rdy = resp_rdy_q;
    assign resp     = resp_q;
    assign timeout  = timeout_q;

endmodule

// File: doc/cfg_host_uart.md
# cfg_host_uart

Host-side command initiator for the 3-byte configuration UART link. It accepts a 24-bit command from the bench or host logic and serializes it MSB first through the shared UART transceiver. It then collects the 2-byte response, MSB first, and presents it as a 16-bit word with a ready flag. It sits at the far end of the serial link from the device-side configuration receiver, with its TX wired to that receiver's RX and vice versa.

## Interface
- TIMEOUT_CYC, default 22'd2_000_000: clk cycles allowed from the LSB tx_done until the second response byte arrives.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- snd_cmd  in  1  one-cycle request to send cmd; honored only in IDLE or RSP_RDY.
- cmd  in  24  command word; sampled on the cycle snd_cmd is accepted.
- clr_resp_rdy  in  1  host acknowledge; drops resp_rdy.
- RX  in  1  serial input from the device's TX.
- TX  out  1  serial output to the device's RX; idles high.
- busy  out  1  high from snd_cmd acceptance until the response is complete or the timeout fires.
- resp_rdy  out  1  response valid; held until clr_resp_rdy or the next accepted snd_cmd.
- resp  out  16  {first rx byte, second rx byte}; stable while resp_rdy is high.
- timeout  out  1  sticky; set on response timeout, cleared by the next accepted snd_cmd.

## Operation
- The command register latches cmd on acceptance. The TX mux selects cmd_q[23:16], then [15:8], then [7:0].
- States:
  - IDLE: on snd_cmd, latch cmd, clear timeout, pulse trmt with the MSB, go to TX_MSB.
  - TX_MSB: on tx_done, pulse trmt with byte 2, go to TX_B2.
  - TX_B2: on tx_done, pulse trmt with the LSB, go to TX_LSB.
  - TX_LSB: on tx_done, clear the timeout counter, go to WAIT_R1.
  - WAIT_R1: on rdy, capture rx_data into resp[15:8], pulse clr_rdy, go to WAIT_R2.
  - WAIT_R2: on rdy, capture rx_data into resp[7:0], pulse clr_rdy, set resp_rdy, go to RSP_RDY.
  - RSP_RDY: clr_resp_rdy clears resp_rdy and goes to IDLE. snd_cmd behaves as in IDLE and also clears resp_rdy.
- Timeout applies in WAIT_R1 and WAIT_R2. The counter increments each cycle. When it reaches TIMEOUT_CYC-1, the block sets timeout, pulses clr_rdy, leaves resp unchanged, does not assert resp_rdy, and goes to IDLE.
- A stray rdy in IDLE or the TX_* states gets a clr_rdy pulse and the byte is discarded. The block never merges stray bytes into resp.
- snd_cmd in any TX_* or WAIT_* state is ignored; cmd_q is unchanged.
- Default case: go to IDLE with all pulses low.

## Timing
- Reset values: state IDLE, busy 0, resp_rdy 0, resp 16'h0000, timeout 0, trmt 0, clr_rdy 0, counter 0, TX 1.
- trmt is a single-cycle combinational pulse. The first trmt asserts in the same cycle snd_cmd is accepted, so the tx_data mux is driven from cmd directly in that cycle.
- Each subsequent trmt asserts in the cycle tx_done is seen high. There is zero idle time between bytes beyond the UART's own stop bit.
- busy rises on the cycle after acceptance (registered). It falls on the same edge resp_rdy rises or timeout sets.
- resp_rdy and resp update on the same clock edge. resp[15:8] is registered in WAIT_R1 and is not visible until resp_rdy.
- If clr_resp_rdy and snd_cmd are high together in RSP_RDY, snd_cmd wins: a new transaction starts and resp_rdy clears.
- The timeout counter is 22 bits and saturates; no wrap-around is possible.
- Reset mid-frame aborts immediately. TX returns high via the UART reset, and a partially received response is discarded.

## Structure
- Shared package (cfg_uart_pkg) holds:
  - the state encoding;
  - the frame lengths CMD_BYTES=3 and RSP_BYTES=2;
  - the default TIMEOUT_CYC.
- The package is shared with the device-side receiver.
- The only sub-module is the existing UART transceiver (UART), instantiated once with ports tx_data, trmt, tx_done, rx_data, rdy, clr_rdy, TX, RX.
- All other logic is flat in this module: FSM, command register, response registers, timeout counter.
- Estimated size is 150–220 lines.

## Test plan
- Loopback to a device-side receiver model:
  - snd_cmd with cmd=24'hA5_3C_0F, then the device answers 16'hBEEF.
  - Required: the device sees frame 24'hA53C0F, then resp_rdy=1, resp=16'hBEEF, busy=0, timeout=0.
- Back-to-back commands:
  - Second snd_cmd with cmd=24'h123456 while in RSP_RDY, without clr_resp_rdy.
  - Required: resp_rdy drops on the next cycle, and the device sees 24'h123456.
- snd_cmd ignored while busy:
  - Pulse snd_cmd with cmd=24'hFFFFFF during TX_B2.
  - Required: the transmitted frame is still the original; the LSB on the wire equals the original cmd[7:0].
- Timeout:
  - TIMEOUT_CYC=1000, the device sends only one byte 8'h77.
  - Required: at 1000 cycles after the LSB tx_done, timeout=1, resp_rdy=0, busy=0, resp unchanged.
  - The next snd_cmd clears timeout.
- Stray byte:
  - Inject 8'h55 on RX while in IDLE, then run a normal transaction with response 16'h0102.
  - Required: resp=16'h0102, not 16'h5501.
- Reset mid-frame:
  - Deassert rst_n during the B2 byte.
  - Required: all outputs at reset values, TX high, and a subsequent transaction completes correctly.
